// File: rtl/spu_result_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : spu_result_writeback
//  Brief    : Stages even/odd pipe results until their write-back slot, drives
//             the register-file write ports and forwards in-flight operands.
//  Revision : 1.0  initial release
// ============================================================================
module spu_result_writeback #(
    parameter int RFWIDTH = 128,
    parameter int REGBITS = 7,
    parameter int DEPTH   = 7,
    parameter int STGBITS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ev_valid,
    input  logic [REGBITS-1:0] ev_rt,
    input  logic [STGBITS-1:0] ev_stage,
    input  logic [RFWIDTH-1:0] ev_result,
    input  logic               od_valid,
    input  logic [REGBITS-1:0] od_rt,
    input  logic [STGBITS-1:0] od_stage,
    input  logic [RFWIDTH-1:0] od_result,
    input  logic               flush,
    input  logic [REGBITS-1:0] ra_0,
    input  logic [REGBITS-1:0] rb_0,
    input  logic [REGBITS-1:0] ra_1,
    input  logic [REGBITS-1:0] rb_1,
    output logic [3:0]         fwd_hit,
    output logic [RFWIDTH-1:0] fwd_ra_0,
    output logic [RFWIDTH-1:0] fwd_rb_0,
    output logic [RFWIDTH-1:0] fwd_ra_1,
    output logic [RFWIDTH-1:0] fwd_rb_1,
    output logic               we_even,
    output logic               we_odd,
    output logic [REGBITS-1:0] wa_even,
    output logic [REGBITS-1:0] wa_odd,
    output logic [RFWIDTH-1:0] wd_even,
    output logic [RFWIDTH-1:0] wd_odd,
    output logic               busy,
    output logic               err_collision,
    output logic               err_waw
);

    localparam logic [STGBITS-1:0] c_depth = STGBITS'(DEPTH);

    // Index 0 is the even pipe, index 1 the odd pipe.
    logic [DEPTH:1]       r_vld  [2];
    logic [REGBITS-1:0]   r_rt   [2][1:DEPTH];
    logic [RFWIDTH-1:0]   r_data [2][1:DEPTH];
    logic                 r_err_coll;
    logic                 r_err_waw;

    logic                 w_in_vld  [2];
    logic [REGBITS-1:0]   w_in_rt   [2];
    logic [STGBITS-1:0]   w_in_stg  [2];
    logic [RFWIDTH-1:0]   w_in_data [2];
    logic [1:0]           w_accept;
    logic [1:0]           w_drop;
    logic [1:0]           w_we;
    logic                 w_waw_now;
    logic [REGBITS-1:0]   w_addr    [4];
    logic [RFWIDTH-1:0]   w_fdata   [4];

    assign w_in_vld[0]  = ev_valid;
    assign w_in_rt[0]   = ev_rt;
    assign w_in_stg[0]  = ev_stage;
    assign w_in_data[0] = ev_result;
    assign w_in_vld[1]  = od_valid;
    assign w_in_rt[1]   = od_rt;
    assign w_in_stg[1]  = od_stage;
    assign w_in_data[1] = od_result;

    // An injection loses its slot to an older entry shifting in from S-1.
    always_comb begin
        logic blocked;
        blocked  = 1'b0;
        w_accept = '0;
        w_drop   = '0;
        for (int p = 0; p < 2; p++) begin
            blocked = 1'b0;
            for (int k = 2; k <= DEPTH; k++) begin
                if (w_in_stg[p] == STGBITS'(k) && r_vld[p][k-1]) blocked = 1'b1;
            end
            if (w_in_vld[p] && !flush) begin
                if (w_in_stg[p] == '0 || w_in_stg[p] > c_depth || blocked) w_drop[p] = 1'b1;
                else w_accept[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld[0]   <= '0;
            r_vld[1]   <= '0;
            r_err_coll <= 1'b0;
            r_err_waw  <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                for (int k = 2; k <= DEPTH; k++) begin
                    r_vld[p][k]  <= r_vld[p][k-1] && !flush;
                    r_rt[p][k]   <= r_rt[p][k-1];
                    r_data[p][k] <= r_data[p][k-1];
                end
                r_vld[p][1] <= 1'b0;
                for (int k = 1; k <= DEPTH; k++) begin
                    if (w_accept[p] && w_in_stg[p] == STGBITS'(k)) begin
                        r_vld[p][k]  <= 1'b1;
                        r_rt[p][k]   <= w_in_rt[p];
                        r_data[p][k] <= w_in_data[p];
                    end
                end
            end
            r_err_coll <= r_err_coll | (|w_drop);
            r_err_waw  <= r_err_waw | w_waw_now;
        end
    end

    // Outputs are held at zero while reset is asserted, even before the edge.
    assign w_we[0]   = r_vld[0][DEPTH] && !reset;
    assign w_we[1]   = r_vld[1][DEPTH] && !reset;
    assign w_waw_now = w_we[0] && w_we[1] && (r_rt[0][DEPTH] == r_rt[1][DEPTH])
                       && (r_rt[0][DEPTH] != '0);

    assign we_even = w_we[0];
    assign we_odd  = w_we[1];
    assign wa_even = w_we[0] ? r_rt[0][DEPTH]   : '0;
    assign wa_odd  = w_we[1] ? r_rt[1][DEPTH]   : '0;
    assign wd_even = w_we[0] ? r_data[0][DEPTH] : '0;
    assign wd_odd  = w_we[1] ? r_data[1][DEPTH] : '0;

    assign busy          = ((|r_vld[0]) || (|r_vld[1])) && !reset;
    assign err_collision = r_err_coll && !reset;
    assign err_waw       = (r_err_waw || w_waw_now) && !reset;

    assign w_addr[0] = ra_0;
    assign w_addr[1] = rb_0;
    assign w_addr[2] = ra_1;
    assign w_addr[3] = rb_1;

    // Scan oldest to newest so the lowest stage (odd pipe on ties) wins.
    for (genvar i = 0; i < 4; i++) begin : g_fwd
        always_comb begin
            fwd_hit[i] = 1'b0;
            w_fdata[i] = '0;
            if (w_addr[i] != '0 && !reset) begin
                for (int k = DEPTH; k >= 1; k--) begin
                    for (int p = 0; p < 2; p++) begin
                        if (r_vld[p][k] && r_rt[p][k] == w_addr[i]) begin
                            fwd_hit[i] = 1'b1;
                            w_fdata[i] = r_data[p][k];
                        end
                    end
                end
            end
        end
    end

    assign fwd_ra_0 = w_fdata[0];
    assign fwd_rb_0 = w_fdata[1];
    assign fwd_ra_1 = w_fdata[2];
    assign fwd_rb_1 = w_fdata[3];

endmodule
`default_nettype wire

// File: tb/tb_spu_result_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spu_result_writeback
//  Brief    : Directed self-checking bench for spu_result_writeback.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spu_result_writeback;

    logic         clk = 1'b0;
    logic         reset;
    logic         ev_valid, od_valid, flush;
    logic [6:0]   ev_rt, od_rt, ra_0, rb_0, ra_1, rb_1;
    logic [2:0]   ev_stage, od_stage;
    logic [127:0] ev_result, od_result;
    logic [3:0]   fwd_hit;
    logic [127:0] fwd_ra_0, fwd_rb_0, fwd_ra_1, fwd_rb_1;
    logic         we_even, we_odd, busy, err_collision, err_waw;
    logic [6:0]   wa_even, wa_odd;
    logic [127:0] wd_even, wd_odd;

    int n_tests = 0;
    int n_fail  = 0;

    spu_result_writeback dut (
        .clk(clk), .reset(reset),
        .ev_valid(ev_valid), .ev_rt(ev_rt), .ev_stage(ev_stage), .ev_result(ev_result),
        .od_valid(od_valid), .od_rt(od_rt), .od_stage(od_stage), .od_result(od_result),
        .flush(flush), .ra_0(ra_0), .rb_0(rb_0), .ra_1(ra_1), .rb_1(rb_1),
        .fwd_hit(fwd_hit), .fwd_ra_0(fwd_ra_0), .fwd_rb_0(fwd_rb_0),
        .fwd_ra_1(fwd_ra_1), .fwd_rb_1(fwd_rb_1),
        .we_even(we_even), .we_odd(we_odd), .wa_even(wa_even), .wa_odd(wa_odd),
        .wd_even(wd_even), .wd_odd(wd_odd), .busy(busy),
        .err_collision(err_collision), .err_waw(err_waw)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ev_valid = 1'b0; ev_rt = '0; ev_stage = '0; ev_result = '0;
        od_valid = 1'b0; od_rt = '0; od_stage = '0; od_result = '0;
        flush = 1'b0;
    endtask

    task automatic inj_ev(input logic [6:0] rt, input logic [2:0] stg, input logic [127:0] d);
        ev_valid = 1'b1; ev_rt = rt; ev_stage = stg; ev_result = d;
    endtask

    task automatic inj_od(input logic [6:0] rt, input logic [2:0] stg, input logic [127:0] d);
        od_valid = 1'b1; od_rt = rt; od_stage = stg; od_result = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic fill_pipes();
        for (int i = 0; i < 7; i++) begin
            inj_ev(7'(10 + i), 3'd1, 128'(i + 1));
            inj_od(7'(20 + i), 3'd1, 128'(256 + i));
            tick();
        end
        idle();
    endtask

    initial begin
        int c, nw, t1, t2, writes;
        logic [127:0] d1, d2;
        d1 = '0; d2 = '0; t1 = 0; t2 = 0;
        idle();
        ra_0 = '0; rb_0 = '0; ra_1 = '0; rb_1 = '0;
        reset = 1'b1;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_we", {we_even, we_odd}, 0);
        check("rst_err", {err_collision, err_waw}, 0);
        reset = 1'b0;

        // Stage-7 injection writes on the very next cycle.
        inj_ev(7'd5, 3'd7, 128'hAA);
        tick();
        idle();
        check("s7_we", we_even, 1);
        check("s7_wa", wa_even, 5);
        check("s7_wd", wd_even, 128'hAA);
        tick();
        check("s7_we_off", we_even, 0);
        check("s7_wa_off", wa_even, 0);
        check("s7_busy", busy, 0);

        // Stage-1 odd result: 7-cycle latency; r0 entry never forwards.
        inj_od(7'd9, 3'd1, 128'h1234);
        inj_ev(7'd0, 3'd1, 128'h55);
        tick();
        idle();
        ra_1 = 7'd9; ra_0 = 7'd0;
        #1;
        check("fwd_hit_ra1", fwd_hit[2], 1);
        check("fwd_ra1", fwd_ra_1, 128'h1234);
        check("fwd_r0_miss", fwd_hit[0], 0);
        c = 1;
        while (!we_odd && c < 20) begin
            tick();
            c++;
        end
        check("s1_latency", c, 7);
        check("s1_wa", wa_odd, 9);
        check("s1_wd", wd_odd, 128'h1234);
        check("r0_write", {we_even, wa_even}, {1'b1, 7'd0});
        ra_1 = '0;
        tick();
        check("s1_busy", busy, 0);

        // Newer value for the same register wins forwarding; writes stay ordered.
        inj_ev(7'd3, 3'd2, 128'd1);
        tick();
        inj_ev(7'd3, 3'd1, 128'd2);
        tick();
        idle();
        ra_0 = 7'd3;
        #1;
        check("newest_hit", fwd_hit[0], 1);
        check("newest_data", fwd_ra_0, 2);
        nw = 0;
        for (c = 2; c < 12; c++) begin
            if (we_even) begin
                if (nw == 0) begin t1 = c; d1 = wd_even; end
                else         begin t2 = c; d2 = wd_even; end
                nw++;
            end
            if (c == 6) check("newest_at_wb", fwd_ra_0, 2);
            tick();
        end
        check("ord_count", nw, 2);
        check("ord_t1", t1, 6);
        check("ord_d1", d1, 1);
        check("ord_t2", t2, 8);
        check("ord_d2", d2, 2);
        check("ord_nocoll", err_collision, 0);
        ra_0 = '0;

        // Blocked injection is dropped; the older result survives.
        inj_ev(7'd4, 3'd3, 128'h33);
        tick();
        inj_ev(7'd6, 3'd4, 128'h44);
        tick();
        idle();
        check("coll_flag", err_collision, 1);
        tick(); tick(); tick();
        check("coll_we", we_even, 1);
        check("coll_wa", wa_even, 4);
        check("coll_wd", wd_even, 128'h33);
        tick();
        check("coll_busy", busy, 0);
        check("coll_sticky", err_collision, 1);

        do_reset();
        #1;
        check("coll_cleared", err_collision, 0);
        inj_od(7'd8, 3'd0, 128'h77);
        tick();
        idle();
        check("stg0_coll", err_collision, 1);
        check("stg0_busy", busy, 0);

        // Flush: only the stage-7 pair writes.
        fill_pipes();
        check("fl_we_e", {we_even, wd_even}, {1'b1, 128'd1});
        check("fl_we_o", {we_odd, wd_odd}, {1'b1, 128'h100});
        flush = 1'b1;
        inj_ev(7'd30, 3'd1, 128'h99);
        tick();
        idle();
        check("fl_we_next", {we_even, we_odd}, 0);
        tick();
        check("fl_busy", busy, 0);
        writes = 0;
        for (int i = 0; i < 8; i++) begin
            writes += int'(we_even) + int'(we_odd);
            tick();
        end
        check("fl_writes", writes, 0);

        // Reset mid-stream: no further writes at all.
        fill_pipes();
        reset = 1'b1;
        #1;
        check("mr_we_gated", {we_even, we_odd}, 0);
        check("mr_busy_gated", busy, 0);
        tick();
        reset = 1'b0;
        writes = 0;
        for (int i = 0; i < 10; i++) begin
            writes += int'(we_even) + int'(we_odd);
            tick();
        end
        check("mr_writes", writes, 0);
        check("mr_busy", busy, 0);
        check("mr_err", {err_collision, err_waw}, 0);

        // Same nonzero address from both pipes in one cycle.
        inj_ev(7'd12, 3'd7, 128'hE);
        inj_od(7'd12, 3'd7, 128'hF);
        tick();
        idle();
        check("waw_we", {we_even, we_odd}, 2'b11);
        check("waw_wa", {wa_even, wa_odd}, {7'd12, 7'd12});
        check("waw_wd", {wd_even[7:0], wd_odd[7:0]}, 16'h0E0F);
        check("waw_flag", err_waw, 1);
        tick();
        check("waw_sticky", {err_waw, we_even, we_odd}, 3'b100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
